pc_commit_tracer: RTL



---
 rtl/pc_commit_tracer_if.sv | 30 +++
 rtl/pc_commit_tracer.sv | 111 +++++++++++
 2 files changed

// File: rtl/pc_commit_tracer_if.sv
// Commit-trace bundle: retirement inputs and the replayed one-per-cycle PC stream with status.
// The core side (master) drives commits and clr_stat; the tracer (slave) returns stream and status.
interface pc_commit_tracer_if #(
    parameter int unsigned PC_W  = 64,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    logic            commit0_vld;
    logic [PC_W-1:0] commit0_pc;
    logic            commit1_vld;
    logic [PC_W-1:0] commit1_pc;
    logic            clr_stat;
    logic            piton_pc_vld;
    logic [PC_W-1:0] piton_pc;
    logic [LvlW-1:0] fill_lvl;
    logic            ovf;
    logic [15:0]     drop_cnt;
    logic            hang;

    modport master (
        output commit0_vld, commit0_pc, commit1_vld, commit1_pc, clr_stat,
        input  piton_pc_vld, piton_pc, fill_lvl, ovf, drop_cnt, hang
    );

    modport slave (
        input  commit0_vld, commit0_pc, commit1_vld, commit1_pc, clr_stat,
        output piton_pc_vld, piton_pc, fill_lvl, ovf, drop_cnt, hang
    );
endinterface

// File: rtl/pc_commit_tracer.sv
// Buffers up to two retired PCs per cycle and replays them one per cycle to pc_cmp,
// tracking overflow drops, occupancy and commit inactivity.
module pc_commit_tracer #(
    parameter int unsigned PC_W        = 64,
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
    input  logic             clk,
    input  logic             rst_l,
    pc_commit_tracer_if.slave trc_io
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned CW = LW + 1;

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            pc_vld_q;
    logic [PC_W-1:0] pc_q;
    logic            ovf_q, ovf_d;
    logic [15:0]     drop_q, drop_d;
    logic [31:0]     idle_q, idle_d;
    logic            hang_q, hang_d;

    logic            pop;
    logic [CW-1:0]   free;
    logic [1:0]      req_n, acc_n, drop_n;
    logic [PC_W-1:0] first_pc;
    logic [16:0]     drop_sum;

    always_comb begin
        pop      = (cnt_q != '0);
        // A same-cycle pop releases the head slot to incoming commits.
        free     = CW'(DEPTH) - CW'(cnt_q) + CW'(pop);
        req_n    = 2'(trc_io.commit0_vld) + 2'(trc_io.commit1_vld);
        acc_n    = req_n;
        if (CW'(req_n) > free) begin
            acc_n = free[1:0];
        end
        drop_n   = req_n - acc_n;
        first_pc = trc_io.commit0_vld ? trc_io.commit0_pc : trc_io.commit1_pc;

        wr_ptr_d = wr_ptr_q + AW'(acc_n);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + LW'(acc_n) - LW'(pop);

        drop_sum = 17'(drop_q) + 17'(drop_n);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        ovf_d    = ovf_q | (drop_n != 2'd0);

        idle_d = idle_q;
        if (acc_n != 2'd0) begin
            idle_d = '0;
        end else if (idle_q != TIMEOUT_CYC) begin
            idle_d = idle_q + 32'd1;
        end
        hang_d = (idle_q == TIMEOUT_CYC);

        if (trc_io.clr_stat) begin
            ovf_d  = 1'b0;
            drop_d = '0;
            idle_d = '0;
            hang_d = 1'b0;
        end
    end

    // Storage carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (acc_n != 2'd0) begin
            mem_q[wr_ptr_q] <= first_pc;
        end
        if (acc_n == 2'd2) begin
            mem_q[wr_ptr_q + AW'(1)] <= trc_io.commit1_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            pc_vld_q <= 1'b0;
            pc_q     <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            idle_q   <= '0;
            hang_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            pc_vld_q <= pop;
            if (pop) begin
                pc_q <= mem_q[rd_ptr_q];
            end
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            idle_q   <= idle_d;
            hang_q   <= hang_d;
        end
    end

    assign trc_io.piton_pc_vld = pc_vld_q;
    assign trc_io.piton_pc     = pc_q;
    assign trc_io.fill_lvl     = cnt_q;
    assign trc_io.ovf          = ovf_q;
    assign trc_io.drop_cnt     = drop_q;
    assign trc_io.hang         = hang_q;
endmodule
